// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared state, opcode and datapath-select encodings for the multicycle RV32I control
package multicycle_control_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R, S_EXEC_I,
        S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_CSR, S_ILLEGAL
    } state_t;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS1 = 2'b01, SRCA_OLDPC = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10;
    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_BR = 2'b01, ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10, M2R_CSR = 2'b11;
    localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JALR = 2'b10;
endpackage

// File: rtl/multicycle_control_instret_counter.sv
// instret_counter: wrapping retired-instruction counter
//   iCLK, iRST_n (async active-low), iEn increment enable, oCount current count
module instret_counter #(
    parameter int W = 32
) (
    input  logic         iCLK,
    input  logic         iRST_n,
    input  logic         iEn,
    output logic [W-1:0] oCount
);
    logic [W-1:0] r_count;
    always_ff @(posedge iCLK or negedge iRST_n)
        if (!iRST_n) r_count <= '0;
        else if (iEn) r_count <= r_count + W'(1);
    assign oCount = r_count;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM sequencing the shared multicycle RV32I datapath
//   iCLK/iRST_n clock and async active-low reset; iOpcode IR[6:0]; iBranchTaken branch result;
//   iMemReady memory handshake; o* datapath enables/selects; oIllegal trap pulse; oInstret retired count.
//   Define CSR_RV_EN to decode opcode 1110011 into the CSR state (otherwise it traps as illegal).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    input  logic [6:0]           iOpcode,
    input  logic                 iBranchTaken,
    input  logic                 iMemReady,
    output logic                 oPCWrite,
    output logic                 oIRWrite,
    output logic                 oRegWrite,
    output logic                 oMemRead,
    output logic                 oMemWrite,
    output logic                 oIorD,
    output logic [1:0]           oALUSrcA,
    output logic [1:0]           oALUSrcB,
    output logic [1:0]           oALUOp,
    output logic [1:0]           oMemToReg,
    output logic [1:0]           oPCSource,
    output logic                 oCsrWrite,
    output logic                 oIllegal,
    output logic [INSTRET_W-1:0] oInstret
);
    state_t r_state, w_next;
    logic   w_retire;

    function automatic state_t decode_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADDR;
            OP_R:              return S_EXEC_R;
            OP_I:              return S_EXEC_I;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
`ifdef CSR_RV_EN
            OP_SYSTEM:         return S_CSR;
`endif
            default:           return S_ILLEGAL;
        endcase
    endfunction

    always_ff @(posedge iCLK or negedge iRST_n)
        if (!iRST_n) r_state <= S_FETCH;
        else r_state <= w_next;

    always_comb begin
        w_next    = S_FETCH;
        w_retire  = 1'b0;
        oPCWrite  = 1'b0;
        oIRWrite  = 1'b0;
        oRegWrite = 1'b0;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        oIorD     = 1'b0;
        oALUSrcA  = SRCA_PC;
        oALUSrcB  = SRCB_RS2;
        oALUOp    = ALUOP_ADD;
        oMemToReg = M2R_ALU;
        oPCSource = PCS_ALU;
        oCsrWrite = 1'b0;
        oIllegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                oMemRead = 1'b1;
                oALUSrcB = SRCB_FOUR;
                oIRWrite = iMemReady;
                oPCWrite = iMemReady;
                w_next   = iMemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                oALUSrcA = SRCA_OLDPC;
                oALUSrcB = SRCB_IMM;
                w_next   = decode_op(iOpcode);
            end
            S_MEMADDR: begin
                oALUSrcA = SRCA_RS1;
                oALUSrcB = SRCB_IMM;
                w_next   = (iOpcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                oMemRead = 1'b1;
                oIorD    = 1'b1;
                w_next   = iMemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                oRegWrite = 1'b1;
                oMemToReg = M2R_MDR;
                w_retire  = 1'b1;
            end
            S_MEMWR: begin
                oMemWrite = 1'b1;
                oIorD     = 1'b1;
                w_retire  = iMemReady;
                w_next    = iMemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                oALUSrcA = SRCA_RS1;
                oALUOp   = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_EXEC_I: begin
                oALUSrcA = SRCA_RS1;
                oALUSrcB = SRCB_IMM;
                oALUOp   = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_LUI: begin
                oALUSrcA = SRCA_ZERO;
                oALUSrcB = SRCB_IMM;
                w_next   = S_ALUWB;
            end
            S_AUIPC: begin
                oALUSrcA = SRCA_OLDPC;
                oALUSrcB = SRCB_IMM;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                oRegWrite = 1'b1;
                w_retire  = 1'b1;
            end
            S_BRANCH: begin
                oALUSrcA  = SRCA_RS1;
                oALUOp    = ALUOP_BR;
                oPCSource = PCS_ALUOUT;
                oPCWrite  = iBranchTaken;
                w_retire  = 1'b1;
            end
            S_JAL: begin
                oRegWrite = 1'b1;
                oMemToReg = M2R_PC;
                oPCWrite  = 1'b1;
                oPCSource = PCS_ALUOUT;
                w_retire  = 1'b1;
            end
            S_JALR: begin
                oALUSrcA  = SRCA_RS1;
                oALUSrcB  = SRCB_IMM;
                oRegWrite = 1'b1;
                oMemToReg = M2R_PC;
                oPCWrite  = 1'b1;
                oPCSource = PCS_JALR;
                w_retire  = 1'b1;
            end
`ifdef CSR_RV_EN
            S_CSR: begin
                oCsrWrite = 1'b1;
                oRegWrite = 1'b1;
                oMemToReg = M2R_CSR;
                w_retire  = 1'b1;
            end
`endif
            S_ILLEGAL: oIllegal = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // PC/IR must never capture while reset is asserted, even though FETCH decode is active
        if (!iRST_n) begin
            oPCWrite = 1'b0;
            oIRWrite = 1'b0;
        end
    end

    instret_counter #(.W(INSTRET_W)) u_instret (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iEn    (w_retire),
        .oCount (oInstret)
    );
endmodule
